wb_fibo_ctrl: RTL and testbench

Wishbone slave register block controlling a parametrised number of Fibonacci generator channels. It replaces the single-channel control block and adds per-channel enable, clock select and value readback. It also adds a maskable, latched interrupt controller and a FIFO mailbox for CPU-to-CPU messaging. It sits between the Caravel Wishbone bus and the generator array.

---
 rtl/wb_fibo_pkg.sv | 26 ++
 rtl/wb_fibo_if.sv | 25 ++
 rtl/wb_mbox_fifo.sv | 50 +++++
 rtl/wb_fibo_ctrl.sv | 135 +++++++++++++
 tb/tb_wb_fibo_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_fibo_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// wb_fibo_pkg : register map and constants for the Fibonacci control block
// Revision 1.0
// ------------------------------------------------------------------
package wb_fibo_pkg;
  localparam logic [6:0] c_off_id          = 7'h00;
  localparam logic [6:0] c_off_info        = 7'h04;
  localparam logic [6:0] c_off_ctrl        = 7'h08;
  localparam logic [6:0] c_off_irq_status  = 7'h0C;
  localparam logic [6:0] c_off_irq_mask    = 7'h10;
  localparam logic [6:0] c_off_irq_set     = 7'h14;
  localparam logic [6:0] c_off_mbox_data   = 7'h18;
  localparam logic [6:0] c_off_mbox_status = 7'h1C;
  localparam logic [6:0] c_off_clock_sel   = 7'h20;
  localparam logic [6:0] c_off_value       = 7'h40;

  localparam logic [31:0] c_id_value   = 32'h4669626F;
  localparam logic [7:0]  c_version    = 8'h02;
  localparam logic [31:0] c_empty_read = 32'hF00DF00D;

  localparam int c_irq_mbox = 0;
  localparam int c_irq_ovf  = 1;
  localparam int c_irq_sw   = 2;
endpackage
`default_nettype wire

// File: rtl/wb_fibo_if.sv
`default_nettype none
// ------------------------------------------------------------------
// wb_fibo_if : Wishbone slave bus bundle for wb_fibo_ctrl
// Revision 1.0
// ------------------------------------------------------------------
interface wb_fibo_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_mbox_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// wb_mbox_fifo : synchronous mailbox FIFO with wrap-bit pointers
// Revision 1.0
// ------------------------------------------------------------------
module wb_mbox_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     wb_clk_i,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_full_cnt = DEPTH[AW:0];
  localparam logic [AW:0] c_one      = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  // The extra pointer bit tells full from empty when the indices match
  assign count = r_wr_ptr - r_rd_ptr;
  assign full  = (count == c_full_cnt);
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign dout  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge wb_clk_i) begin
    if (!reset && push && !full) begin
      r_mem[r_wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push && !full) r_wr_ptr <= r_wr_ptr + c_one;
      if (pop && !empty) r_rd_ptr <= r_rd_ptr + c_one;
    end
  end
endmodule
`default_nettype wire

// File: rtl/wb_fibo_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// wb_fibo_ctrl : Wishbone register block for Fibonacci generator channels
// Revision 1.0
// ------------------------------------------------------------------
module wb_fibo_ctrl
  import wb_fibo_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
  parameter int          CHANNELS     = 2,
  parameter int          CLOCK_WIDTH  = 6,
  parameter int          VAL_WIDTH    = 30,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic                            wb_clk_i,
  input  logic                            reset,
  wb_fibo_if.slave                        wbs,
  input  logic [CHANNELS*VAL_WIDTH-1:0]   val_i,
  output logic [CHANNELS-1:0]             switch,
  output logic [CHANNELS*CLOCK_WIDTH-1:0] clock_sel,
  output logic [2:0]                      irq
);
  localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;

  logic                   r_ack;
  logic [31:0]            r_dat;
  logic [CHANNELS-1:0]    r_switch;
  logic [CLOCK_WIDTH-1:0] r_clk_sel [CHANNELS];
  logic [2:0]             r_mask;
  logic                   r_irq_ovf;
  logic                   r_irq_sw;

  logic [31:0]        w_off;
  logic [6:0]         w_reg;
  logic               w_accept;
  logic               w_wr;
  logic               w_rd;
  logic [31:0]        w_rdata;
  logic [2:0]         w_status;
  logic               w_push;
  logic               w_pop;
  logic [31:0]        w_mbox_dout;
  logic [c_cnt_w-1:0] w_count;
  logic               w_full;
  logic               w_empty;
  logic               w_set_ovf;
  logic               w_set_sw;
  logic               w_clr;

  // Subtracting the base makes the window test independent of alignment
  assign w_off    = wbs.wbs_adr_i - BASE_ADDRESS;
  assign w_reg    = {w_off[6:2], 2'b00};
  assign w_accept = wbs.wbs_stb_i && wbs.wbs_cyc_i && (w_off < 32'h80) && !r_ack;
  assign w_wr     = w_accept && wbs.wbs_we_i && (wbs.wbs_sel_i == 4'hF);
  assign w_rd     = w_accept && !wbs.wbs_we_i;

  assign w_push = w_wr && (w_reg == c_off_mbox_data);
  assign w_pop  = w_rd && (w_reg == c_off_mbox_data) && !w_empty;

  wb_mbox_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_mbox (
    .wb_clk_i (wb_clk_i),
    .reset    (reset),
    .push     (w_push),
    .pop      (w_pop),
    .din      (wbs.wbs_dat_i),
    .dout     (w_mbox_dout),
    .count    (w_count),
    .full     (w_full),
    .empty    (w_empty)
  );

  assign w_status  = {r_irq_sw, r_irq_ovf, !w_empty};
  assign irq       = w_status & r_mask;
  assign w_set_ovf = (w_push && w_full) ||
                     (w_wr && (w_reg == c_off_irq_set) && wbs.wbs_dat_i[c_irq_ovf]);
  assign w_set_sw  = w_wr && (w_reg == c_off_irq_set) && wbs.wbs_dat_i[c_irq_sw];
  assign w_clr     = w_wr && (w_reg == c_off_irq_status);

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      c_off_id:          w_rdata = c_id_value;
      c_off_info:        w_rdata = {8'(CHANNELS), 8'(FIFO_DEPTH), 8'(CLOCK_WIDTH), c_version};
      c_off_ctrl:        w_rdata = 32'(r_switch);
      c_off_irq_status:  w_rdata = 32'(w_status);
      c_off_irq_mask:    w_rdata = 32'(r_mask);
      c_off_mbox_data:   w_rdata = w_empty ? c_empty_read : w_mbox_dout;
      c_off_mbox_status: w_rdata = {19'b0, 5'(w_count), 6'b0, w_full, w_empty};
      default:           w_rdata = '0;
    endcase
    for (int n = 0; n < CHANNELS; n++) begin
      if (w_reg == c_off_clock_sel + 7'(4 * n)) w_rdata = 32'(r_clk_sel[n]);
      if (w_reg == c_off_value + 7'(4 * n))     w_rdata = 32'(val_i[n*VAL_WIDTH +: VAL_WIDTH]);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      r_ack     <= 1'b0;
      r_dat     <= '0;
      r_switch  <= '1;
      r_mask    <= '0;
      r_irq_ovf <= 1'b0;
      r_irq_sw  <= 1'b0;
      for (int n = 0; n < CHANNELS; n++) r_clk_sel[n] <= CLOCK_WIDTH'(1);
    end else begin
      r_ack <= w_accept;
      r_dat <= w_rd ? w_rdata : '0;
      if (w_wr && (w_reg == c_off_ctrl))     r_switch <= wbs.wbs_dat_i[CHANNELS-1:0];
      if (w_wr && (w_reg == c_off_irq_mask)) r_mask   <= wbs.wbs_dat_i[2:0];
      // A hardware or software set beats a simultaneous clear
      if (w_set_ovf)                                  r_irq_ovf <= 1'b1;
      else if (w_clr && wbs.wbs_dat_i[c_irq_ovf])     r_irq_ovf <= 1'b0;
      if (w_set_sw)                                   r_irq_sw  <= 1'b1;
      else if (w_clr && wbs.wbs_dat_i[c_irq_sw])      r_irq_sw  <= 1'b0;
      for (int n = 0; n < CHANNELS; n++) begin
        if (w_wr && (w_reg == c_off_clock_sel + 7'(4 * n))) begin
          r_clk_sel[n] <= wbs.wbs_dat_i[CLOCK_WIDTH-1:0];
        end
      end
    end
  end

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    assign clock_sel[n*CLOCK_WIDTH +: CLOCK_WIDTH] = r_clk_sel[n];
  end

  assign switch        = r_switch;
  assign wbs.wbs_ack_o = r_ack && !reset;
  assign wbs.wbs_dat_o = (r_ack && !reset) ? r_dat : '0;
endmodule
`default_nettype wire

// File: tb/tb_wb_fibo_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_wb_fibo_ctrl : self-checking bench for wb_fibo_ctrl
// Revision 1.0
// ------------------------------------------------------------------
module tb_wb_fibo_ctrl;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] EMPTY_RD = 32'hF00DF00D;

  logic        wb_clk_i = 1'b0;
  logic        reset;
  logic [59:0] val_i;
  logic [1:0]  switch;
  logic [11:0] clock_sel;
  logic [2:0]  irq;

  wb_fibo_if wbs();

  wb_fibo_ctrl #(
    .BASE_ADDRESS (BASE),
    .CHANNELS     (2),
    .CLOCK_WIDTH  (6),
    .VAL_WIDTH    (30),
    .FIFO_DEPTH   (4)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .reset     (reset),
    .wbs       (wbs),
    .val_i     (val_i),
    .switch    (switch),
    .clock_sel (clock_sel),
    .irq       (irq)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] mq[$];
  bit          m_ovf, m_sw;
  logic [2:0]  m_mask;
  logic [1:0]  m_switch;
  logic [5:0]  m_clk [2];

  function automatic logic [31:0] m_status();
    return {29'b0, m_sw, m_ovf, (mq.size() != 0)};
  endfunction

  function automatic logic [31:0] m_mbox_status();
    return {19'b0, 5'(mq.size()), 6'b0, (mq.size() == 4), (mq.size() == 0)};
  endfunction

  function automatic void m_push(input logic [31:0] d);
    if (mq.size() < 4) mq.push_back(d);
    else m_ovf = 1'b1;
  endfunction

  function automatic logic [31:0] m_pop();
    if (mq.size() == 0) return EMPTY_RD;
    return mq.pop_front();
  endfunction

  function automatic void m_reset();
    mq.delete();
    m_ovf = 0; m_sw = 0; m_mask = '0; m_switch = 2'b11;
    m_clk[0] = 6'd1; m_clk[1] = 6'd1;
  endfunction

  task automatic xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rdata, output int lat);
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wbs.wbs_stb_i = 1'b1; wbs.wbs_cyc_i = 1'b1; wbs.wbs_we_i = we;
    wbs.wbs_adr_i = adr;  wbs.wbs_dat_i = dat;  wbs.wbs_sel_i = sel;
    lat = -1; rdata = '0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs.wbs_ack_o === 1'b1) begin
        lat = i; rdata = wbs.wbs_dat_o;
        break;
      end
    end
    wbs.wbs_stb_i = 1'b0; wbs.wbs_cyc_i = 1'b0; wbs.wbs_we_i = 1'b0;
  endtask

  task automatic bus_wr(input logic [31:0] off, input logic [31:0] dat, input logic [3:0] sel = 4'hF);
    logic [31:0] d; int l;
    xfer(1'b1, BASE + off, dat, sel, d, l);
  endtask

  task automatic bus_rd(input logic [31:0] off, output logic [31:0] d);
    int l;
    xfer(1'b0, BASE + off, 32'h0, 4'hF, d, l);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    bus_rd(32'h00, d); total++;
    if (d !== 32'h4669626F) begin bad++; $display("FAIL id: got %h want %h", d, 32'h4669626F); end
    bus_rd(32'h04, d); total++;
    if (d !== 32'h02040602) begin bad++; $display("FAIL info: got %h want %h", d, 32'h02040602); end
    bus_rd(32'h08, d); total++;
    if (d !== 32'h3) begin bad++; $display("FAIL ctrl_rst: got %h want %h", d, 32'h3); end
    bus_rd(32'h20, d); total++;
    if (d !== 32'h1) begin bad++; $display("FAIL clksel_rst: got %h want %h", d, 32'h1); end
    total++;
    if (switch !== 2'b11) begin bad++; $display("FAIL switch_rst: got %b want 11", switch); end
    total++;
    if (clock_sel !== {6'd1, 6'd1}) begin bad++; $display("FAIL clock_sel_rst: got %h want %h", clock_sel, {6'd1, 6'd1}); end
    total++;
    if (irq !== 3'b000) begin bad++; $display("FAIL irq_rst: got %b want 000", irq); end
  endtask

  task automatic test_clock_sel();
    logic [31:0] d, v; int l, ch; logic [3:0] sel;
    xfer(1'b1, BASE + 32'h24, 32'h15, 4'hF, d, l); total++;
    if (l !== 1) begin bad++; $display("FAIL ack_lat_wr: got %0d want 1", l); end
    total++;
    if (clock_sel[11:6] !== 6'h15) begin bad++; $display("FAIL clksel_wr: got %h want 15", clock_sel[11:6]); end
    @(posedge wb_clk_i); #1; total++;
    if (wbs.wbs_ack_o !== 1'b0) begin bad++; $display("FAIL ack_one_cycle: got %b want 0", wbs.wbs_ack_o); end
    xfer(1'b1, BASE + 32'h24, 32'h3F, 4'h3, d, l); total++;
    if (l !== 1) begin bad++; $display("FAIL ack_lat_sel: got %0d want 1", l); end
    total++;
    if (clock_sel[11:6] !== 6'h15) begin bad++; $display("FAIL clksel_sel3: got %h want 15", clock_sel[11:6]); end
    m_clk[1] = 6'h15;
    for (int i = 0; i < 8; i++) begin
      ch = int'($urandom_range(1, 0));
      v = $urandom;
      sel = ($urandom_range(1, 0) == 1) ? 4'hF : 4'($urandom_range(14, 0));
      bus_wr(32'h20 + 32'(4 * ch), v, sel);
      if (sel == 4'hF) m_clk[ch] = v[5:0];
      total++;
      if (clock_sel !== {m_clk[1], m_clk[0]}) begin bad++; $display("FAIL clksel_out: got %h want %h", clock_sel, {m_clk[1], m_clk[0]}); end
      bus_rd(32'h20 + 32'(4 * ch), d); total++;
      if (d !== 32'(m_clk[ch])) begin bad++; $display("FAIL clksel_rd: got %h want %h", d, 32'(m_clk[ch])); end
    end
    for (int i = 0; i < 4; i++) begin
      v = $urandom;
      bus_wr(32'h08, v);
      m_switch = v[1:0];
      total++;
      if (switch !== m_switch) begin bad++; $display("FAIL switch: got %b want %b", switch, m_switch); end
      bus_rd(32'h08, d); total++;
      if (d !== 32'(m_switch)) begin bad++; $display("FAIL ctrl_rd: got %h want %h", d, 32'(m_switch)); end
    end
  endtask

  task automatic test_mailbox();
    logic [31:0] d, v, e;
    bus_wr(32'h10, 32'h3); m_mask = 3'b011;
    for (int i = 0; i < 5; i++) begin
      v = $urandom; bus_wr(32'h18, v); m_push(v);
    end
    bus_rd(32'h1C, d); total++;
    if (d !== m_mbox_status()) begin bad++; $display("FAIL mbox_full: got %h want %h", d, m_mbox_status()); end
    bus_rd(32'h0C, d); total++;
    if (d !== m_status()) begin bad++; $display("FAIL status_ovf: got %h want %h", d, m_status()); end
    total++;
    if (irq !== (m_status() & 32'(m_mask)) ) begin bad++; $display("FAIL irq_ovf: got %b want %b", irq, m_status() & 32'(m_mask)); end
    bus_wr(32'h0C, 32'h1);
    bus_rd(32'h0C, d); total++;
    if (d !== m_status()) begin bad++; $display("FAIL bit0_noclr: got %h want %h", d, m_status()); end
    for (int i = 0; i < 5; i++) begin
      bus_rd(32'h18, d); e = m_pop(); total++;
      if (d !== e) begin bad++; $display("FAIL pop%0d: got %h want %h", i, d, e); end
    end
    bus_rd(32'h0C, d); total++;
    if (d !== m_status()) begin bad++; $display("FAIL status_empty: got %h want %h", d, m_status()); end
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(1, 0) == 1) begin
        v = $urandom; bus_wr(32'h18, v); m_push(v);
      end else begin
        bus_rd(32'h18, d); e = m_pop(); total++;
        if (d !== e) begin bad++; $display("FAIL rnd_pop: got %h want %h", d, e); end
      end
      bus_rd(32'h1C, d); total++;
      if (d !== m_mbox_status()) begin bad++; $display("FAIL rnd_mstat: got %h want %h", d, m_mbox_status()); end
    end
    while (mq.size() != 0) begin
      bus_rd(32'h18, d); e = m_pop(); total++;
      if (d !== e) begin bad++; $display("FAIL drain: got %h want %h", d, e); end
    end
    bus_wr(32'h0C, 32'h2); m_ovf = 0;
    bus_rd(32'h0C, d); total++;
    if (d !== m_status()) begin bad++; $display("FAIL w1c_ovf: got %h want %h", d, m_status()); end
  endtask

  task automatic test_irq();
    logic [31:0] d, v, e;
    bus_wr(32'h14, 32'h4); m_sw = 1;
    bus_wr(32'h10, 32'h4); m_mask = 3'b100;
    total++;
    if (irq !== 3'b100) begin bad++; $display("FAIL irq_sw: got %b want 100", irq); end
    bus_rd(32'h14, d); total++;
    if (d !== 32'h0) begin bad++; $display("FAIL irqset_rd: got %h want 0", d); end
    bus_wr(32'h14, 32'h2, 4'h3);
    bus_rd(32'h0C, d); total++;
    if (d !== m_status()) begin bad++; $display("FAIL irqset_sel: got %h want %h", d, m_status()); end
    bus_wr(32'h14, 32'h2); m_ovf = 1;
    bus_rd(32'h0C, d); total++;
    if (d !== m_status()) begin bad++; $display("FAIL irqset_b1: got %h want %h", d, m_status()); end
    bus_wr(32'h0C, 32'h6); m_sw = 0; m_ovf = 0;
    total++;
    if (irq !== 3'b000) begin bad++; $display("FAIL irq_w1c: got %b want 000", irq); end
    for (int i = 0; i < 5; i++) begin
      v = $urandom; bus_wr(32'h18, v); m_push(v);
    end
    bus_wr(32'h0C, 32'h2); m_ovf = 0;
    v = $urandom; bus_wr(32'h18, v); m_push(v);
    bus_rd(32'h0C, d); total++;
    if (d !== m_status()) begin bad++; $display("FAIL ovf_after_w1c: got %h want %h", d, m_status()); end
    while (mq.size() != 0) begin
      bus_rd(32'h18, d); e = m_pop(); total++;
      if (d !== e) begin bad++; $display("FAIL irq_drain: got %h want %h", d, e); end
    end
    bus_wr(32'h0C, 32'h7); m_ovf = 0;
    bus_wr(32'h10, 32'h0); m_mask = '0;
  endtask

  task automatic test_value();
    logic [31:0] d; int l; logic [29:0] v0, v1;
    for (int i = 0; i < 4; i++) begin
      v0 = 30'($urandom);
      v1 = (i == 0) ? 30'h2AAAAAAA : 30'($urandom);
      val_i = {v1, v0};
      bus_rd(32'h44, d); total++;
      if (d !== {2'b00, v1}) begin bad++; $display("FAIL value1: got %h want %h", d, {2'b00, v1}); end
      bus_rd(32'h40, d); total++;
      if (d !== {2'b00, v0}) begin bad++; $display("FAIL value0: got %h want %h", d, {2'b00, v0}); end
    end
    bus_wr(32'h48, 32'hFFFF_FFFF);
    bus_wr(32'h28, 32'hFFFF_FFFF);
    xfer(1'b0, BASE + 32'h48, 32'h0, 4'hF, d, l); total++;
    if (l !== 1 || d !== 32'h0) begin bad++; $display("FAIL value_oob: got lat=%0d d=%h want lat=1 d=0", l, d); end
    bus_rd(32'h28, d); total++;
    if (d !== 32'h0) begin bad++; $display("FAIL clksel_oob: got %h want 0", d); end
    xfer(1'b0, BASE + 32'h7C, 32'h0, 4'hF, d, l); total++;
    if (l !== 1 || d !== 32'h0) begin bad++; $display("FAIL unmapped: got lat=%0d d=%h want lat=1 d=0", l, d); end
    total++;
    if (clock_sel !== {m_clk[1], m_clk[0]}) begin bad++; $display("FAIL oob_side: got %h want %h", clock_sel, {m_clk[1], m_clk[0]}); end
    xfer(1'b0, BASE + 32'h80, 32'h0, 4'hF, d, l); total++;
    if (l !== -1) begin bad++; $display("FAIL out_hi: got lat=%0d want no ack", l); end
    xfer(1'b0, BASE - 32'h4, 32'h0, 4'hF, d, l); total++;
    if (l !== -1) begin bad++; $display("FAIL out_lo: got lat=%0d want no ack", l); end
  endtask

  task automatic test_back_to_back();
    int acks; bit prev; bit dbl; bit bad_dat;
    acks = 0; prev = 0; dbl = 0; bad_dat = 0;
    @(posedge wb_clk_i); @(negedge wb_clk_i);
    wbs.wbs_stb_i = 1'b1; wbs.wbs_cyc_i = 1'b1; wbs.wbs_we_i = 1'b0;
    wbs.wbs_adr_i = BASE; wbs.wbs_sel_i = 4'hF;
    for (int i = 0; i < 8; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs.wbs_ack_o === 1'b1) begin
        acks++;
        if (prev) dbl = 1;
        if (wbs.wbs_dat_o !== 32'h4669626F) bad_dat = 1;
      end else if (wbs.wbs_dat_o !== 32'h0) bad_dat = 1;
      prev = (wbs.wbs_ack_o === 1'b1);
    end
    wbs.wbs_stb_i = 1'b0; wbs.wbs_cyc_i = 1'b0;
    total++;
    if (acks != 4 || dbl || bad_dat) begin
      bad++; $display("FAIL back_to_back: got acks=%0d dbl=%0b dat_err=%0b want acks=4 dbl=0 dat_err=0", acks, dbl, bad_dat);
    end
  endtask

  task automatic test_reset_inflight();
    logic [31:0] d; int acks;
    bus_wr(32'h18, 32'h1111_2222);
    bus_wr(32'h18, 32'h3333_4444);
    bus_wr(32'h10, 32'h7);
    bus_wr(32'h08, 32'h1);
    bus_wr(32'h24, 32'h9);
    @(posedge wb_clk_i); @(negedge wb_clk_i);
    wbs.wbs_stb_i = 1'b1; wbs.wbs_cyc_i = 1'b1; wbs.wbs_we_i = 1'b0;
    wbs.wbs_adr_i = BASE + 32'h18; wbs.wbs_sel_i = 4'hF;
    @(posedge wb_clk_i); #1;
    reset = 1'b1;
    acks = 0;
    #1;
    if (wbs.wbs_ack_o !== 1'b0) acks++;
    wbs.wbs_stb_i = 1'b0; wbs.wbs_cyc_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs.wbs_ack_o !== 1'b0) acks++;
    end
    @(negedge wb_clk_i); reset = 1'b0;
    @(posedge wb_clk_i); #1;
    if (wbs.wbs_ack_o !== 1'b0) acks++;
    m_reset();
    total++;
    if (acks != 0) begin bad++; $display("FAIL rst_ack: got %0d acks want 0", acks); end
    total++;
    if (switch !== 2'b11 || clock_sel !== {6'd1, 6'd1} || irq !== 3'b000) begin
      bad++; $display("FAIL rst_outs: got sw=%b cs=%h irq=%b want 11 041 000", switch, clock_sel, irq);
    end
    bus_rd(32'h1C, d); total++;
    if (d !== m_mbox_status()) begin bad++; $display("FAIL rst_mbox: got %h want %h", d, m_mbox_status()); end
    bus_rd(32'h0C, d); total++;
    if (d !== m_status()) begin bad++; $display("FAIL rst_status: got %h want %h", d, m_status()); end
    bus_rd(32'h10, d); total++;
    if (d !== 32'h0) begin bad++; $display("FAIL rst_mask: got %h want 0", d); end
    bus_rd(32'h18, d); total++;
    if (d !== EMPTY_RD) begin bad++; $display("FAIL rst_pop: got %h want %h", d, EMPTY_RD); end
  endtask

  initial begin
    int rst_acks;
    reset = 1'b1;
    val_i = '0;
    wbs.wbs_stb_i = 1'b1; wbs.wbs_cyc_i = 1'b1; wbs.wbs_we_i = 1'b0;
    wbs.wbs_sel_i = 4'hF; wbs.wbs_adr_i = BASE; wbs.wbs_dat_i = '0;
    m_reset();
    rst_acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs.wbs_ack_o !== 1'b0) rst_acks++;
    end
    total++;
    if (rst_acks != 0) begin bad++; $display("FAIL ack_in_reset: got %0d acks want 0", rst_acks); end
    wbs.wbs_stb_i = 1'b0; wbs.wbs_cyc_i = 1'b0;
    @(negedge wb_clk_i); reset = 1'b0;

    test_reset();
    test_clock_sel();
    test_mailbox();
    test_irq();
    test_value();
    test_back_to_back();
    test_reset_inflight();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
